// File: rtl/frac_pkg.sv
// Shared definitions for the fractional-pel SAD search block.
package frac_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_FLUSH = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Sixteen quarter-pel candidates, k = 4*fy + fx.
    localparam int NUM_CAND = 16;

    // Accumulator width: one pixel's worth of range times the pixel count.
    function automatic int sad_width(input int pix_w, input int blk_w, input int blk_h);
        return pix_w + $clog2(blk_w * blk_h);
    endfunction

endpackage

// File: rtl/frac_sad_search_if.sv
// Row-streaming input and result output of the fractional SAD search.
interface frac_sad_search_if
    import frac_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int BLK_W = 8,
    parameter int BLK_H = 8
) ();
    localparam int SAD_W = sad_width(PIX_W, BLK_W, BLK_H);

    logic                   in_valid;
    logic                   in_ready;
    logic [PIX_W*BLK_W-1:0] filter_row;
    logic [PIX_W*BLK_W-1:0] ref_row;
    logic [1:0]             mvx;
    logic [1:0]             mvy;
    logic [SAD_W-1:0]       best_sad;
    logic                   out_valid;
    logic                   busy;

    modport master (
        output in_valid, filter_row, ref_row,
        input  in_ready, mvx, mvy, best_sad, out_valid, busy
    );

    modport slave (
        input  in_valid, filter_row, ref_row,
        output in_ready, mvx, mvy, best_sad, out_valid, busy
    );
endinterface

// File: rtl/frac_interp.sv
// Bilinear quarter-pel interpolator for a single pixel; purely combinational.
module frac_interp #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    input  logic [PIX_W-1:0] d,
    input  logic [1:0]       fx,
    input  logic [1:0]       fy,
    output logic [PIX_W-1:0] pred
);
    // Weights sum to 16, so the rounded result always fits back in PIX_W.
    localparam int W = PIX_W + 5;

    logic [W-1:0] wx0, wx1, wy0, wy1, sum;

    assign wx1  = W'(fx);
    assign wx0  = W'(4) - wx1;
    assign wy1  = W'(fy);
    assign wy0  = W'(4) - wy1;
    assign sum  = wx0 * wy0 * W'(a) + wx1 * wy0 * W'(b)
                + wx0 * wy1 * W'(c) + wx1 * wy1 * W'(d) + W'(8);
    assign pred = PIX_W'(sum >> 4);
endmodule

// File: rtl/frac_sad_search.sv
// Quarter-pel motion refinement: streams a block row by row, accumulates
// 16 candidate SADs in parallel, then scans them for the minimum.
module frac_sad_search
    import frac_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int BLK_W = 8,
    parameter int BLK_H = 8
) (
    input  logic             clk,
    input  logic             reset,
    frac_sad_search_if.slave bus
);
    localparam int SAD_W = sad_width(PIX_W, BLK_W, BLK_H);
    localparam int ROW_W = $clog2(BLK_H);

    typedef logic [BLK_W-1:0][PIX_W-1:0] row_t;

    state_t                              state, state_nx;
    logic [ROW_W-1:0]                    row_cnt;
    logic [3:0]                          cand_cnt;
    row_t                                prev_f, prev_r, cur_f, bot_f;
    logic [NUM_CAND-1:0][SAD_W-1:0]      sad, row_sad;
    logic [NUM_CAND-1:0][BLK_W-1:0][PIX_W-1:0] pred;
    logic [SAD_W-1:0]                    min_sad, cand_sad, best_q;
    logic [3:0]                          min_k, best_k;
    logic [1:0]                          mvx_q, mvy_q;
    logic                                take, accept, acc_en;

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
        return (x >= y) ? x - y : y - x;
    endfunction

    assign accept = bus.in_valid & bus.in_ready;
    assign cur_f  = bus.filter_row;
    // In FLUSH the last row has no successor, so it is its own vertical neighbour.
    assign bot_f  = (state == S_FLUSH) ? prev_f : cur_f;
    assign acc_en = (state == S_FLUSH) || (state == S_RECV && accept);

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_cand
        for (genvar i = 0; i < BLK_W; i++) begin : g_pix
            localparam int IB = (i == BLK_W - 1) ? i : i + 1;
            frac_interp #(.PIX_W(PIX_W)) u_interp (
                .a(prev_f[i]), .b(prev_f[IB]), .c(bot_f[i]), .d(bot_f[IB]),
                .fx(2'(k % 4)), .fy(2'(k / 4)), .pred(pred[k][i])
            );
        end
    end

    // Per-candidate SAD contribution of the row currently being interpolated.
    always_comb begin
        row_sad = '0;
        for (int k = 0; k < NUM_CAND; k++)
            for (int i = 0; i < BLK_W; i++)
                row_sad[k] = row_sad[k] + SAD_W'(absdiff(pred[k][i], prev_r[i]));
    end

    // Running-minimum comparator; strict less-than keeps the lowest index on ties.
    always_comb begin
        cand_sad = sad[cand_cnt];
        take     = (cand_cnt == 4'd0) || (cand_sad < min_sad);
        best_k   = take ? cand_cnt : min_k;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_RECV;
            S_RECV:  if (accept && row_cnt == ROW_W'(BLK_H - 1)) state_nx = S_FLUSH;
            S_FLUSH: state_nx = S_CMP;
            S_CMP:   if (cand_cnt == 4'd15) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        bus.in_ready  = !reset && (state == S_IDLE || state == S_RECV);
        bus.busy      = (state != S_IDLE);
        bus.out_valid = (state == S_DONE);
    end

    assign bus.mvx      = mvx_q;
    assign bus.mvy      = mvy_q;
    assign bus.best_sad = best_q;

    // Row buffer, accumulators, candidate scan and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt  <= '0;
            cand_cnt <= '0;
            prev_f   <= '0;
            prev_r   <= '0;
            sad      <= '0;
            min_sad  <= '0;
            min_k    <= '0;
            mvx_q    <= '0;
            mvy_q    <= '0;
            best_q   <= '0;
        end else begin
            if (accept) begin
                prev_f <= cur_f;
                prev_r <= bus.ref_row;
            end
            if (state == S_IDLE && accept) begin
                row_cnt <= ROW_W'(1);
                sad     <= '0;
            end
            if (state == S_RECV && accept)
                row_cnt <= row_cnt + ROW_W'(1);
            if (acc_en)
                for (int k = 0; k < NUM_CAND; k++)
                    sad[k] <= sad[k] + row_sad[k];
            if (state == S_FLUSH)
                cand_cnt <= '0;
            if (state == S_CMP) begin
                cand_cnt <= cand_cnt + 4'd1;
                min_sad  <= take ? cand_sad : min_sad;
                min_k    <= best_k;
                if (cand_cnt == 4'd15) begin
                    mvx_q  <= best_k[1:0];
                    mvy_q  <= best_k[3:2];
                    best_q <= take ? cand_sad : min_sad;
                end
            end
        end
    end
endmodule

// File: doc/frac_sad_search.md
FRAC_SAD_SEARCH -- requirements
Module: frac_sad_search

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter BLK_W, default 8, pixels per row (>=2).
REQ-003 Parameter BLK_H, default 8, rows per block (>=2).
REQ-004 Derived constant SAD_W SHALL be PIX_W + clog2(BLK_W*BLK_H), which is 14 at the defaults.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  filter_row and ref_row are valid this cycle.
REQ-008 in_ready  output  1  block accepts a row this cycle; a row is accepted when in_valid and in_ready are both high.
REQ-009 filter_row  input  PIX_W*BLK_W  row of the block to be interpolated; pixel i is at bits [i*PIX_W +: PIX_W].
REQ-010 ref_row  input  PIX_W*BLK_W  co-located reference row, same packing.
REQ-011 mvx, mvy  output  2 each  best quarter-pel offset (fx, fy), each in 0..3.
REQ-012 best_sad  output  SAD_W  SAD of the winning candidate.
REQ-013 out_valid  output  1  one-cycle pulse; mvx, mvy and best_sad are valid.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, RECV, FLUSH, CMP, DONE.
REQ-016 in_ready SHALL be 1 in IDLE and RECV, 0 in FLUSH, CMP and DONE, and 0 while reset is high.
REQ-017 IDLE: an accepted row is stored as row 0 and the block moves to RECV. No accumulation happens in IDLE.
REQ-018 RECV: accepting row r (1..BLK_H-1) accumulates candidate SADs for row r-1, using rows r-1 and r.
REQ-019 RECV: after row BLK_H-1 is accepted, the block moves to FLUSH.
REQ-020 RECV: in_valid gaps are allowed; the state holds and nothing is accumulated.
REQ-021 FLUSH (1 cycle): accumulates row BLK_H-1 with its vertical neighbour clamped to itself.
REQ-022 Candidates: 16, index k = 4*fy + fx.
REQ-023 Interpolation per pixel i: pred = ((4-fx)(4-fy)A + fx(4-fy)B + (4-fx)fy C + fx*fy D + 8) >> 4, where:
  - A = filter[r][i], B = filter[r][i+1], C = filter[r+1][i], D = filter[r+1][i+1];
  - at i = BLK_W-1, B = A and D = C;
  - in FLUSH, C = A and D = B;
  - intermediates are unsigned, PIX_W+5 bits; the result is never saturated.
REQ-024 Each row adds sum over i of |pred - ref[r][i]| to SAD[k] for all 16 candidates in parallel.
REQ-025 SAD accumulators are SAD_W bits, cannot overflow, and are cleared on entry to RECV from IDLE.
REQ-026 CMP: lasts exactly 16 cycles and evaluates candidate k = 0..15, one per cycle.
REQ-027 CMP: a running minimum is replaced only on a strictly smaller SAD, so ties resolve to the lowest k.
REQ-028 DONE (1 cycle): out_valid = 1; mvx = k_best mod 4, mvy = k_best / 4; then the block returns to IDLE.
REQ-029 Latency: out_valid is high in the 18th cycle after the edge that accepted the last row (1 FLUSH + 16 CMP + 1).
REQ-030 mvx, mvy and best_sad are registered, hold their value until the next DONE, and are 0 after reset.
REQ-031 out_valid, in_ready and busy are 0 after reset; the state after reset is IDLE.
REQ-032 A row presented while in_ready = 0 is not consumed; the source must keep holding it.

Reset
REQ-033 Reset SHALL clear the following on the next edge, in any state including mid-block:
  - state, row counter and candidate counter;
  - all SAD accumulators and the running minimum;
  - the stored previous row;
  - all outputs.
REQ-034 The first accepted row after reset is treated as row 0 of a new block.

Structure
REQ-035 Shared package frac_pkg: state encoding, NUM_CAND = 16, and the function that computes SAD_W from PIX_W, BLK_W and BLK_H.
REQ-036 Sub-module frac_interp: combinational bilinear interpolator, one pixel, four neighbours plus fx and fy in, pred out; instantiated per pixel and per candidate.
REQ-037 The top level contains the FSM, row buffer, accumulators, comparator and handshake; no other sub-modules.

Verification
REQ-038 Flat block: all filter and ref pixels = 100, 8 consecutive rows -> mvx = 0, mvy = 0, best_sad = 0; out_valid pulses once, 18 cycles after row 7.
REQ-039 Horizontal half-pel: filter[r][i] = 16i; ref[r][i] = 16i+8 for i < 7 and ref[r][7] = 112 -> mvx = 2, mvy = 0, best_sad = 0.
REQ-040 Backpressure: in_valid low for 3 cycles between rows 2 and 3 -> same result as the gap-free run, with out_valid delayed by exactly 3 cycles.
REQ-041 Rows driven during FLUSH, CMP or DONE -> in_ready = 0, no row consumed, result unchanged.
REQ-042 Reset after 4 rows, then a full flat block -> outputs are 0 during reset; the next result is (0, 0, 0) with no residue from the aborted block.
REQ-043 Tie: filter = ref = vertical ramp filter[r][i] = 20r -> fy = 0 wins over equal-SAD candidates; mvx = 0, mvy = 0, lowest index chosen.
